regfile_wb_arbiter: RTL

Write-port arbiter and sequencer for the core's 32x32 `register_file`. The register file has a single write port. This block shares that port between two writeback sources: the ALU/execute stage and the load/memory unit. It drives the `rd_addr`, `rd_data` and `reg_write` inputs of `register_file`. Arbitration favours the ALU, and a starvation counter guarantees forward progress for loads. Writes to x0 are suppressed, and write-port conflicts are counted for performance debug.

---
 rtl/regfile_wb_arbiter.sv | 69 ++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and load writeback with anti-starvation
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        reg_write,
  output logic [15:0] conflict_count
);
  typedef enum logic {ALU_PRIO, MEM_FORCE} state_t;
  localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);
  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        reg_write_q, reg_write_d;
  logic [15:0] conflict_q, conflict_d;
  logic        grant_mem, grant_alu, blocked;
  logic [4:0]  sel_rd;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ALU_PRIO;
      wait_q      <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      reg_write_q <= 1'b0;
      conflict_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      reg_write_q <= reg_write_d;
      conflict_q  <= conflict_d;
    end
  end
  always_comb begin
    blocked = mem_valid & !grant_mem;
    wait_d  = !blocked ? 4'd0 : (wait_q == 4'd15) ? 4'd15 : wait_q + 4'd1;
    state_d = (state_q == ALU_PRIO)
            ? ((blocked && wait_q != 4'd15 && {1'b0, wait_q} + 5'd1 == LIMIT) ? MEM_FORCE : ALU_PRIO)
            : ((grant_mem || !mem_valid) ? ALU_PRIO : MEM_FORCE);
  end
  always_comb begin
    grant_mem   = mem_valid & (!alu_valid | (state_q == MEM_FORCE));
    grant_alu   = alu_valid & !grant_mem;
    mem_ready   = grant_mem;
    alu_stall   = alu_valid & grant_mem;
    sel_rd      = grant_mem ? mem_rd : alu_rd;
    rd_addr_d   = (grant_mem | grant_alu) ? sel_rd : rd_addr_q;
    rd_data_d   = grant_mem ? mem_data : grant_alu ? alu_data : rd_data_q;
    reg_write_d = (grant_mem | grant_alu) & (sel_rd != 5'd0);
    conflict_d  = conflict_q + {15'd0, alu_valid & mem_valid};
  end
  assign rd_addr        = rd_addr_q;
  assign rd_data        = rd_data_q;
  assign reg_write      = reg_write_q;
  assign conflict_count = conflict_q;
endmodule
